// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell sequenced over WIDTH cycles, LSB first.
// Optional macro SERIAL_ADD_SUB_EN adds a `sub` input for two's-complement subtraction.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n_1,
    input  logic [WIDTH-1:0] n_2,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             faSum, faCout;
    logic [WIDTH-1:0] opB;
    logic             carryIn;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (faSum),
        .cout (faCout)
    );

    // Subtraction is n_1 + ~n_2 + 1, so only the loaded operand and carry change.
`ifdef SERIAL_ADD_SUB_EN
    assign opB     = sub ? ~n_2 : n_2;
    assign carryIn = sub ? 1'b1 : cin;
`else
    assign opB     = n_2;
    assign carryIn = cin;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = faCout;
                sum_d   = {faSum, sum_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cout_d  = faCout;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE otherwise falls to IDLE.
                if (start) begin
                    state_d = RUN;
                    a_d     = n_1;
                    b_d     = opB;
                    carry_d = carryIn;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl; covers the SERIAL_ADD_SUB_EN build when defined.

module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] n1, n2;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .n_1   (n1),
        .n_2   (n2),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    int edgeCount = 0;
    always @(posedge clk) edgeCount++;

    typedef struct {
        logic [WIDTH:0] value;
        int             doneAt;
    } exp_t;

    exp_t           sbQ[$];
    exp_t           popped;
    logic [WIDTH:0] lastResult = '0;
    int             checks     = 0;
    int             failures   = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: plain arithmetic on the operands, independent of the bit-serial mechanics.
    function automatic logic [WIDTH:0] modelResult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                   input logic c, input logic s);
        logic [WIDTH:0] r;
        if (s) r = {(a >= b), WIDTH'(a - b)};
        else   r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL spurious_done: got done=1, expected no outstanding request (t=%0t)", $time);
            end else begin
                popped = sbQ.pop_front();
                checkOutput("result", 64'({cout, sum}), 64'(popped.value));
                checkOutput("latency_edge", 64'(edgeCount), 64'(popped.doneAt));
                checkOutput("busy_in_done", 64'(busy), 64'd0);
            end
        end
    end

    // Called from a negedge while the DUT is idle or presenting done; returns just after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s);
        exp_t e;
        n1    = a;
        n2    = b;
        cin   = c;
`ifdef SERIAL_ADD_SUB_EN
        sub   = s;
`endif
        start = 1'b1;
        e.value  = modelResult(a, b, c, s);
        e.doneAt = edgeCount + 1 + WIDTH;
        sbQ.push_back(e);
        lastResult = e.value;
        @(posedge clk);
        #1;
        start = 1'b0;
        n1    = WIDTH'($urandom);
        n2    = WIDTH'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got no done, expected done within %0d cycles", name, 4 * WIDTH);
        end
    endtask

    task automatic checkIdleHold(input string name);
        @(negedge clk);
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
        checkOutput({name, "_done"}, 64'(done), 64'd0);
        checkOutput({name, "_held"}, 64'({cout, sum}), 64'(lastResult));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        n1    = '0;
        n2    = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rst_busy", 64'(busy), 64'd0);
            checkOutput("rst_done", 64'(done), 64'd0);
            checkOutput("rst_sum",  64'(sum),  64'd0);
            checkOutput("rst_cout", 64'(cout), 64'd0);
        end

        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        waitDone("add_12_34");
        checkIdleHold("after_12_34");

        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        waitDone("add_ff_01");
        checkIdleHold("after_ff_01");

        applyStimulus(8'h5A, 8'hA5, 1'b1, 1'b0);
        waitDone("add_5a_a5");
        checkIdleHold("after_5a_a5");

        // A start pulse mid-run must be ignored.
        applyStimulus(8'h33, 8'h44, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        n1    = 8'hEE;
        n2    = 8'hDD;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone("ignore_start");

        // Back-to-back: start held during the done cycle.
        applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("b2b_busy", 64'(busy), 64'd1);
        waitDone("b2b");
        checkIdleHold("after_b2b");

        // Reset in the middle of a run discards the operation.
        applyStimulus(8'h77, 8'h88, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sbQ.delete();
        lastResult = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_sum",  64'(sum),  64'd0);
        checkOutput("midrst_cout", 64'(cout), 64'd0);
        repeat (2 * WIDTH) @(negedge clk);
        applyStimulus(8'h0F, 8'h01, 1'b1, 1'b0);
        waitDone("after_midrst");
        checkIdleHold("after_midrst");

`ifdef SERIAL_ADD_SUB_EN
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b1);
        waitDone("sub_10_01");
        checkIdleHold("after_sub_10_01");
        applyStimulus(8'h00, 8'h01, 1'b1, 1'b1);
        waitDone("sub_00_01");
        checkIdleHold("after_sub_00_01");
`endif

        // Random traffic with a mix of back-to-back and gapped requests.
        for (int i = 0; i < 30; i++) begin
            logic s;
`ifdef SERIAL_ADD_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), s);
            waitDone("random");
            if ($urandom_range(1) == 0) checkIdleHold("random_gap");
        end
        checkIdleHold("final");

        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. Accepts two WIDTH-bit operands plus carry-in on a start/done handshake, then sequences one internally instantiated `full_adder` cell over WIDTH clock cycles, one bit per cycle, LSB first. Provides multi-bit addition from the single-bit `full_adder` datapath, trading latency for area.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only when idle or in the done cycle.
- `n_1`  input  WIDTH  operand A; sampled on the accepting edge only.
- `n_2`  input  WIDTH  operand B; sampled on the accepting edge only.
- `cin`  input  1  carry-in; sampled on the accepting edge only.
- `sub`  input  1  subtract select; present only with `SERIAL_ADD_SUB_EN`.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse: `sum` and `cout` are valid.
- `sum`  output  WIDTH  result; held until the next accepted start.
- `cout`  output  1  final carry-out; held like `sum`.

Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.

## Operation

- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on `start`.
  - RUN to DONE when the bit counter reaches WIDTH-1.
  - DONE to RUN if `start` is high (back-to-back request), otherwise DONE to IDLE.
- On the accepting edge:
  - `n_1` and `n_2` load into operand shift registers.
  - The carry register loads `cin`.
  - The bit counter clears.
  - The `sum` register clears.
- Each RUN cycle:
  - `full_adder` inputs are operand LSBs and the carry register.
  - The adder's `sum` bit shifts into the result register from the MSB end.
  - The adder's `cout` is written to the carry register.
  - Both operand registers shift right by one.
  - The counter increments.
- On the edge leaving RUN, the final carry register value drives `cout`.
- `start` is ignored while in RUN, and operand inputs are don't-care outside the accepting edge.
- Arithmetic: result is `{cout, sum}` = `n_1 + n_2 + cin`, exact to WIDTH+1 bits, with no truncation.
- Reset (any state, including mid-RUN):
  - Next state is IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - Counter and carry register are 0.
  - The in-flight operation is discarded with no `done`.

## Timing

- Accepting edge is E0 (`start`=1 sampled in IDLE or DONE).
- `busy` is 1 from after E0 through the cycle ending at edge E(WIDTH); it is 0 in IDLE and DONE.
- Bit i is computed in the cycle between E(i) and E(i+1), for i = 0..WIDTH-1.
- `done`=1 for exactly one cycle, after edge E(WIDTH). Latency from the accepting edge to `done` is WIDTH cycles.
- `sum`/`cout` are stable and valid from the `done` cycle until the next accepting edge.
- Back-to-back: `start` held during the `done` cycle is accepted there. `busy` rises the next cycle, with no idle gap, for a throughput of one result per WIDTH+1 cycles.
- During RUN, the `sum` output shows partial shift contents. Only read it when `done`=1 or afterwards.

## Configuration

- Macro `SERIAL_ADD_SUB_EN`.
- Defined:
  - The `sub` port exists and is sampled with the operands.
  - When `sub`=1, the `n_2` register loads `~n_2`, the carry register loads 1, and `cin` is ignored.
  - Result: `sum` = `n_1 - n_2` mod 2^WIDTH, with `cout`=1 meaning no borrow.
  - When `sub`=0, behaviour is identical to the undefined build.
- Undefined: no `sub` port; addition only.

## Test plan

- Reset, then idle 5 cycles. Expect `busy`=0, `done`=0, `sum`=0, `cout`=0 throughout.
- WIDTH=8, operands 0x12 + 0x34 with `cin`=0:
  - Expect `done` exactly 8 cycles after the accepting edge.
  - Expect `sum`=0x46, `cout`=0.
- WIDTH=8, carry propagation:
  - 0xFF + 0x01, `cin`=0: expect `sum`=0x00, `cout`=1.
  - 0x5A + 0xA5, `cin`=1: expect `sum`=0x00, `cout`=1.
- Busy and back-to-back handling:
  - Pulse `start` at RUN cycle 3 with different operands: expect it ignored and the first result unchanged.
  - Hold `start` in the `done` cycle with 0x01 + 0x01: expect the next `done` 8 cycles later with `sum`=0x02.
- Reset mid-operation: assert `rst` at RUN cycle 4.
  - Expect `busy`=0, `sum`=0, `cout`=0 on the next cycle.
  - Expect no `done` pulse.
  - A new start afterwards must complete correctly.
- With `SERIAL_ADD_SUB_EN`, `sub`=1:
  - 0x10 - 0x01: expect `sum`=0x0F, `cout`=1.
  - 0x00 - 0x01: expect `sum`=0xFF, `cout`=0.
